mem_bus_if: RTL
===============

// Module: mem_bus_if
// PURPOSE
//  MAR/MDR memory bus interface; sits directly downstream of unidad_control.
//  - Consumes wmar/wmdr/i_o/rmem/wmem; bus_in is the internal data bus (AC/PC/SP via rac/rpc/rsp).
//  - Runs a req/ack transaction to data memory with wait states and a timeout.
//  - MDR contents return to the register file through mdr_out.
// PARAMETERS
//  DATA_W   16  data bus / MDR width
//  ADDR_W   16  MAR / memory address width
//  TIMEOUT  15  max cycles in REQ waiting for mem_ack before error (1..255)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  bus_in     in   DATA_W  internal data bus
//  wmar       in   1       MAR <= bus_in[ADDR_W-1:0]
//  wmdr       in   1       MDR <= bus_in when i_o=0
//  i_o        in   1       MDR source: 0 bus, 1 memory (read path owned by rmem)
//  rmem       in   1       start memory read into MDR
//  wmem       in   1       start memory write of MDR to [MAR]
//  mdr_out    out  DATA_W  MDR contents, registered
//  mem_addr   out  ADDR_W  latched transaction address
//  mem_wdata  out  DATA_W  latched write data
//  mem_we     out  1       1 write / 0 read; valid while mem_req
//  mem_req    out  1       request, registered, held until ack or timeout
//  mem_ack    in   1       memory completion, sampled on clk
//  mem_rdata  in   DATA_W  read data, valid when mem_ack=1 and mem_we=0
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse, transaction completed OK
//  mem_err    out  1       sticky timeout flag, cleared only by reset
//  ovr        out  1       sticky overrun flag, cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; MAR, MDR, mem_addr, mem_wdata, mem_we = 0.
//   mem_req, busy, done, mem_err, ovr = 0; timeout counter = 0.
//  FSM: IDLE, REQ, DONE, ERR.
//  IDLE:
//   - wmar: MAR loads at the edge.
//   - wmdr & !i_o: MDR loads at the edge.
//   - wmdr & i_o without rmem: no effect.
//   - rmem|wmem: latch mem_addr=MAR, mem_wdata=MDR and mem_we=wmem, all pre-update
//     values; same-cycle wmar/wmdr still update MAR/MDR. -> REQ, mem_req=1 next cycle.
//   - rmem & wmem together: write wins, ovr<=1.
//  REQ:
//   - mem_req=1; mem_addr, mem_wdata and mem_we held stable.
//   - Counter increments each cycle; mem_ack sampled at each edge.
//   - ack: if read, MDR<=mem_rdata; mem_req<=0; -> DONE.
//   - no ack and counter==TIMEOUT-1: mem_req<=0, mem_err<=1; -> ERR.
//  DONE: done=1 for one cycle; -> IDLE. Commands in DONE are handled as in IDLE.
//  ERR: one cycle; MDR unchanged; done stays 0; -> IDLE.
//  Commands while busy:
//   - wmar, wmdr, rmem or wmem asserted in REQ or ERR is dropped; MAR/MDR unchanged.
//   - ovr<=1.
//  Latency:
//   - Command at edge E, mem_req high in cycle E+1.
//   - Zero-wait ack in E+1: MDR valid and done=1 in cycle E+2, busy low in E+3.
//   - Back-to-back commands possible from DONE.
//  Ack timing: mem_ack outside REQ is ignored.
//  Reset mid-transaction: mem_req drops at the next edge, state IDLE, any in-flight read
//   is discarded.
// TESTING
//  - bus_in=0x0040,wmar; bus_in=0xBEEF,wmdr,i_o=0; wmem, ack after 2 waits -> mem_addr=0x0040,
//    mem_wdata=0xBEEF, mem_we=1, req high 3 cycles, done pulse once.
//  - MAR=0x0012; rmem; zero-wait ack, rdata=0x1234 -> mdr_out=0x1234 at E+2, done at E+2.
//  - rmem, no ack -> mem_req low after exactly 15 cycles; mem_err=1 stays set; MDR unchanged.
//  - During REQ pulse wmar, bus_in=0x00FF -> MAR and mem_addr unchanged; ovr=1.
//  - rmem&wmem same cycle -> mem_we=1, write performed, ovr=1.
//  - reset asserted in 2nd REQ cycle -> mem_req=0, busy=0 next cycle; late ack ignored;
//    MDR=0.

Source files
------------

// File: rtl/mem_bus_if.sv
// mem_bus_if: MAR/MDR bus interface running req/ack memory transactions
// with wait states, timeout error and sticky overrun reporting.
module mem_bus_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              wmar,
    input  logic              wmdr,
    input  logic              i_o,
    input  logic              rmem,
    input  logic              wmem,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              mem_err,
    output logic              ovr
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_mar, r_addr;
    logic [DATA_W-1:0] r_mdr, r_wdata;
    logic [7:0]        r_cnt;
    logic              r_we, r_err, r_ovr;
    logic              w_free, w_start, w_cmd, w_tmo;
    assign w_free  = (r_state == IDLE) || (r_state == DONE);
    assign w_start = w_free && (rmem || wmem);
    assign w_cmd   = wmar || wmdr || rmem || wmem;
    assign w_tmo   = r_cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE, DONE: w_next = w_start ? REQ : IDLE;
            REQ:        w_next = mem_ack ? DONE : (w_tmo ? ERR : REQ);
            default:    w_next = IDLE;
        endcase
    end
    // Transaction fields capture pre-edge MAR/MDR so same-cycle loads affect only the next access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mar   <= '0;
            r_mdr   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_free) begin
                if (wmar) r_mar <= bus_in[ADDR_W-1:0];
                if (wmdr && !i_o) r_mdr <= bus_in;
                if (w_start) begin
                    r_addr  <= r_mar;
                    r_wdata <= r_mdr;
                    r_we    <= wmem;
                    r_cnt   <= '0;
                end
                if (rmem && wmem) r_ovr <= 1'b1;
            end
            if (r_state == REQ) begin
                r_cnt <= r_cnt + 8'd1;
                if (mem_ack && !r_we) r_mdr <= mem_rdata;
                if (!mem_ack && w_tmo) r_err <= 1'b1;
            end
            if (!w_free && w_cmd) r_ovr <= 1'b1;
        end
    end
    assign mdr_out   = r_mdr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign mem_req   = r_state == REQ;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign mem_err   = r_err;
    assign ovr       = r_ovr;
endmodule
